// File: rtl/lpc_host.sv
// lpc_host: LPC host issuing single IO read/write cycles with SYNC wait handling, timeout abort and registered outputs
module lpc_host #(
   parameter int SHORT_WAIT_MAX = 3,
   parameter int LONG_WAIT_MAX  = 1023,
   parameter int NOSYNC_MAX     = 3
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic        req_valid,
   input  logic [3:0]  req_cyctype_dir,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        lpc_frame,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   input  logic [3:0]  lpc_ad_in,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status,
   output logic [7:0]  rdata
);
   localparam int SW = $clog2(SHORT_WAIT_MAX + 2);
   localparam int LW = $clog2(LONG_WAIT_MAX + 2);
   localparam int NW = $clog2(NOSYNC_MAX + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CTDIR, S_ADDR, S_WDATA, S_TAR1, S_SYNC, S_RDATA, S_TAR2, S_ABORT, S_DONE
   } state_t;

   state_t        r_state, w_next;
   logic [2:0]    r_idx, w_idx;
   logic [3:0]    r_ct;
   logic [15:0]   r_addr;
   logic [7:0]    r_wdata;
   logic [SW-1:0] r_short;
   logic [LW-1:0] r_long;
   logic [NW-1:0] r_nosync;
   logic          w_req_ok, w_write, w_sync_end, w_short, w_long, w_abort;
   logic          w_frame, w_oe;
   logic [3:0]    w_ad, w_addr_nib;

   assign w_req_ok   = req_cyctype_dir == 4'b0000 || req_cyctype_dir == 4'b0010;
   assign w_write    = r_ct == 4'b0010;
   assign w_sync_end = lpc_ad_in == 4'b0000 || lpc_ad_in == 4'b1010;
   assign w_short    = lpc_ad_in == 4'b0101;
   assign w_long     = lpc_ad_in == 4'b0110;
   // abort when the counter for this nibble is already at its limit, i.e. this nibble would exceed it
   assign w_abort    = w_short ? r_short == SW'(SHORT_WAIT_MAX) :
                       w_long  ? r_long == LW'(LONG_WAIT_MAX) : r_nosync == NW'(NOSYNC_MAX);

   always_comb begin
      w_next = r_state;
      w_idx  = r_idx + 3'd1;
      case (r_state)
         S_IDLE:  w_next = !req_valid ? S_IDLE : w_req_ok ? S_START : S_DONE;
         S_START: w_next = S_CTDIR;
         S_CTDIR: begin
            w_next = S_ADDR;
            w_idx  = 3'd0;
         end
         S_ADDR: if (r_idx == 3'd3) begin
            w_next = w_write ? S_WDATA : S_TAR1;
            w_idx  = 3'd0;
         end
         S_WDATA: if (r_idx == 3'd1) begin
            w_next = S_TAR1;
            w_idx  = 3'd0;
         end
         S_TAR1: if (r_idx == 3'd1) begin
            w_next = S_SYNC;
            w_idx  = 3'd0;
         end
         S_SYNC: begin
            w_idx  = 3'd0;
            w_next = w_sync_end ? (w_write ? S_TAR2 : S_RDATA) : w_abort ? S_ABORT : S_SYNC;
         end
         S_RDATA: if (r_idx == 3'd1) begin
            w_next = S_TAR2;
            w_idx  = 3'd0;
         end
         S_TAR2:  if (r_idx == 3'd1) w_next = S_DONE;
         S_ABORT: if (r_idx == 3'd4) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs are decoded from the next state so they land in registers with no extra latency
   assign w_addr_nib = w_idx[1] ? (w_idx[0] ? r_addr[3:0] : r_addr[7:4]) : (w_idx[0] ? r_addr[11:8] : r_addr[15:12]);
   assign w_frame    = !(w_next == S_START || (w_next == S_ABORT && w_idx != 3'd4));
   assign w_oe       = !(w_next == S_SYNC || w_next == S_RDATA || w_next == S_TAR2 || (w_next == S_TAR1 && w_idx == 3'd1));
   assign w_ad       = w_next == S_START ? 4'b0000 :
                       w_next == S_CTDIR ? r_ct :
                       w_next == S_ADDR  ? w_addr_nib :
                       w_next == S_WDATA ? (w_idx[0] ? r_wdata[7:4] : r_wdata[3:0]) : 4'b1111;

   always_ff @(posedge lpc_clock) begin
      if (lpc_reset) begin
         r_state    <= S_IDLE;
         r_idx      <= 3'd0;
         r_ct       <= 4'd0;
         r_addr     <= 16'd0;
         r_wdata    <= 8'd0;
         r_short    <= '0;
         r_long     <= '0;
         r_nosync   <= '0;
         status     <= 2'b00;
         rdata      <= 8'd0;
         lpc_frame  <= 1'b1;
         lpc_ad_out <= 4'b1111;
         lpc_ad_oe  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_idx      <= w_idx;
         lpc_frame  <= w_frame;
         lpc_ad_out <= w_ad;
         lpc_ad_oe  <= w_oe;
         busy       <= w_next != S_IDLE && w_next != S_DONE;
         done       <= w_next == S_DONE;
         if (r_state == S_IDLE && req_valid) begin
            r_ct    <= req_cyctype_dir;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            status  <= w_req_ok ? 2'b00 : 2'b11;
         end
         if (r_state == S_TAR1) begin
            r_short  <= '0;
            r_long   <= '0;
            r_nosync <= '0;
         end
         if (r_state == S_SYNC) begin
            if (lpc_ad_in == 4'b1010) status <= 2'b01;
            else if (!w_sync_end) begin
               if (w_abort) status <= 2'b10;
               else if (w_short) r_short <= r_short + 1'b1;
               else if (w_long) r_long <= r_long + 1'b1;
               else r_nosync <= r_nosync + 1'b1;
            end
         end
         if (r_state == S_RDATA) begin
            if (r_idx[0]) rdata[7:4] <= lpc_ad_in;
            else rdata[3:0] <= lpc_ad_in;
         end
      end
   end
endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: randomized LPC host bench with a per-cycle expected-output queue built from the bus protocol rules
module tb_lpc_host;
   localparam int SW_MAX = 3;
   localparam int LW_MAX = 1023;
   localparam int NS_MAX = 3;

   logic        lpc_clock = 1'b0;
   logic        lpc_reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [3:0]  req_cyctype_dir = 4'h0;
   logic [15:0] req_addr = 16'h0;
   logic [7:0]  req_wdata = 8'h0;
   logic        lpc_frame, lpc_ad_oe, busy, done;
   logic [3:0]  lpc_ad_out;
   logic [3:0]  lpc_ad_in = 4'hf;
   logic [1:0]  status;
   logic [7:0]  rdata;

   lpc_host dut (
      .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .req_valid(req_valid),
      .req_cyctype_dir(req_cyctype_dir), .req_addr(req_addr), .req_wdata(req_wdata),
      .lpc_frame(lpc_frame), .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe), .lpc_ad_in(lpc_ad_in),
      .busy(busy), .done(done), .status(status), .rdata(rdata)
   );

   always #5 lpc_clock = ~lpc_clock;

   typedef struct {
      logic       frame;
      logic       oe;
      logic [3:0] ad;
      logic       busy;
      logic       done;
      logic       chk_st;
      logic [3:0] lad;
      logic [1:0] st;
      logic [7:0] rd;
   } ent_t;

   ent_t       q[$];
   int         checks = 0, errors = 0;
   logic [1:0] c_status = 2'b00, m_status = 2'b00;
   logic [7:0] c_rdata = 8'h00, m_rdata = 8'h00;
   int         mon_busy, mon_ni, mon_run, mon_last_run, mon_low, mon_done;
   logic [3:0] mon_nib[16];
   logic [1:0] mon_st;
   logic [7:0] mon_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic ent_t mk(input logic f, input logic o, input logic [3:0] a, input logic b, input logic d, input logic [3:0] l);
      ent_t e;
      e.frame = f; e.oe = o; e.ad = a; e.busy = b; e.done = d; e.lad = l;
      e.chk_st = 1'b0; e.st = 2'b00; e.rd = 8'h00;
      return e;
   endfunction

   function automatic logic [3:0] rn();
      return 4'($urandom);
   endfunction

   function automatic logic [3:0] other_nib();
      logic [3:0] n;
      do n = 4'($urandom); while (n == 4'h0 || n == 4'h5 || n == 4'h6 || n == 4'ha);
      return n;
   endfunction

   function automatic logic [31:0] nibs(input int n);
      logic [31:0] r = 32'h0;
      for (int i = 0; i < n; i++) r = {r[27:0], mon_nib[i]};
      return r;
   endfunction

   // compare process: one expected entry per cycle while a transaction is in flight, idle values otherwise
   initial begin
      ent_t e;
      forever begin
         @(posedge lpc_clock);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("frame", lpc_frame, e.frame);
            chk("ad_oe", lpc_ad_oe, e.oe);
            if (e.oe) chk("ad_out", lpc_ad_out, e.ad);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            if (e.chk_st) chk("status", status, e.st);
            if (e.done) begin
               chk("rdata", rdata, e.rd);
               c_status = e.st;
               c_rdata  = e.rd;
            end
         end else begin
            chk("idle_frame", lpc_frame, 1'b1);
            chk("idle_oe", lpc_ad_oe, 1'b1);
            chk("idle_ad", lpc_ad_out, 4'hf);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_status", status, c_status);
            chk("idle_rdata", rdata, c_rdata);
         end
         if (busy) mon_busy++;
         if (busy && lpc_ad_oe && mon_ni < 16) begin
            mon_nib[mon_ni] = lpc_ad_out;
            mon_ni++;
         end
         if (!lpc_frame) begin
            mon_run++;
            mon_low++;
         end else begin
            if (mon_run != 0) mon_last_run = mon_run;
            mon_run = 0;
         end
         if (done) begin
            mon_done++;
            mon_st = status;
            mon_rd = rdata;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge lpc_clock);
         req_valid = 1'b0;
         lpc_ad_in = rn();
      end
   endtask

   // wtype: 0 no waits, 1 short-wait 0101, 2 long-wait 0110, 3 non-SYNC nibbles; rst_at = cycle index to reset in
   task automatic run_txn(input logic [3:0] ct, input logic [15:0] addr, input logic [7:0] wd, input int wtype,
                          input int k, input logic [3:0] term, input logic [7:0] data, input int rst_at);
      ent_t       t[$];
      ent_t       e;
      logic       wr, ab;
      logic [1:0] st;
      logic [3:0] nib;
      int         cs, cl, cn, kk;
      wr = ct == 4'h2; ab = 1'b0; st = 2'b00; cs = 0; cl = 0; cn = 0;
      kk = (wtype == 0) ? 0 : k;
      if (!(ct == 4'h0 || ct == 4'h2)) st = 2'b11;
      else begin
         e = mk(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, rn()); e.chk_st = 1'b1; t.push_back(e);
         t.push_back(mk(1'b1, 1'b1, ct, 1'b1, 1'b0, rn()));
         for (int i = 0; i < 4; i++) t.push_back(mk(1'b1, 1'b1, addr[15-4*i -: 4], 1'b1, 1'b0, rn()));
         if (wr) begin
            t.push_back(mk(1'b1, 1'b1, wd[3:0], 1'b1, 1'b0, rn()));
            t.push_back(mk(1'b1, 1'b1, wd[7:4], 1'b1, 1'b0, rn()));
         end
         t.push_back(mk(1'b1, 1'b1, 4'hf, 1'b1, 1'b0, rn()));
         t.push_back(mk(1'b1, 1'b0, 4'hf, 1'b1, 1'b0, rn()));
         for (int j = 0; j <= kk; j++) begin
            nib = (j < kk) ? (wtype == 1 ? 4'h5 : wtype == 2 ? 4'h6 : other_nib()) : term;
            t.push_back(mk(1'b1, 1'b0, 4'hf, 1'b1, 1'b0, nib));
            if (nib == 4'h0 || nib == 4'ha) begin
               st = (nib == 4'ha) ? 2'b01 : 2'b00;
               break;
            end
            if (nib == 4'h5) cs++;
            else if (nib == 4'h6) cl++;
            else cn++;
            if (cs > SW_MAX || cl > LW_MAX || cn > NS_MAX) begin
               ab = 1'b1;
               break;
            end
         end
         if (ab) begin
            repeat (4) t.push_back(mk(1'b0, 1'b1, 4'hf, 1'b1, 1'b0, rn()));
            t.push_back(mk(1'b1, 1'b1, 4'hf, 1'b1, 1'b0, rn()));
            st = 2'b10;
         end else begin
            if (!wr) begin
               t.push_back(mk(1'b1, 1'b0, 4'hf, 1'b1, 1'b0, data[3:0]));
               t.push_back(mk(1'b1, 1'b0, 4'hf, 1'b1, 1'b0, data[7:4]));
               m_rdata = data;
            end
            t.push_back(mk(1'b1, 1'b0, 4'hf, 1'b1, 1'b0, 4'hf));
            t.push_back(mk(1'b1, 1'b0, 4'hf, 1'b1, 1'b0, rn()));
         end
      end
      e = mk(1'b1, 1'b1, 4'hf, 1'b0, 1'b1, rn()); e.chk_st = 1'b1; e.st = st; e.rd = m_rdata;
      t.push_back(e);
      m_status = st;
      @(negedge lpc_clock);
      req_valid = 1'b1; req_cyctype_dir = ct; req_addr = addr; req_wdata = wd; lpc_ad_in = rn();
      mon_busy = 0; mon_ni = 0; mon_run = 0; mon_last_run = 0; mon_low = 0; mon_done = 0;
      mon_st = 2'bxx; mon_rd = 8'hxx;
      foreach (t[i]) q.push_back(t[i]);
      for (int i = 0; i < t.size(); i++) begin
         @(negedge lpc_clock);
         if (i == rst_at) begin
            lpc_reset = 1'b1; req_valid = 1'b0;
            q.delete();
            m_status = 2'b00; m_rdata = 8'h00; c_status = 2'b00; c_rdata = 8'h00;
            @(negedge lpc_clock);
            lpc_reset = 1'b0;
            return;
         end
         lpc_ad_in       = t[i].lad;
         req_valid       = 1'($urandom);
         req_cyctype_dir = rn();
         req_addr        = 16'($urandom);
         req_wdata       = 8'($urandom);
      end
   endtask

   initial begin
      repeat (2) @(negedge lpc_clock);
      lpc_reset = 1'b0;
      idle(2);
      run_txn(4'h0, 16'h7fe5, 8'h00, 0, 0, 4'h0, 8'h6c, -1);
      chk("rd_nibbles", nibs(6), 32'h00007fe5);
      chk("rd_len", mon_busy, 13);
      chk("rd_done_cnt", mon_done, 1);
      chk("rd_rdata", mon_rd, 8'h6c);
      chk("rd_status", mon_st, 2'b00);
      idle(1);
      run_txn(4'h2, 16'h0080, 8'ha5, 1, 3, 4'h0, 8'h00, -1);
      chk("wr_nibbles", nibs(8), 32'h0200805a);
      chk("wr_len", mon_busy, 16);
      chk("wr_status", mon_st, 2'b00);
      chk("wr_rdata_held", mon_rd, 8'h6c);
      idle(1);
      run_txn(4'h0, 16'h1234, 8'h00, 1, 4, 4'h0, 8'h00, -1);
      chk("abort_frame_run", mon_last_run, 4);
      chk("abort_status", mon_st, 2'b10);
      run_txn(4'h0, 16'h4321, 8'h00, 0, 0, 4'ha, 8'hff, -1);
      chk("syncerr_status", mon_st, 2'b01);
      chk("syncerr_rdata", mon_rd, 8'hff);
      run_txn(4'h4, 16'h5555, 8'h00, 0, 0, 4'h0, 8'h00, -1);
      chk("unsup_busy", mon_busy, 0);
      chk("unsup_frame_low", mon_low, 0);
      chk("unsup_status", mon_st, 2'b11);
      chk("unsup_done_cnt", mon_done, 1);
      run_txn(4'h2, 16'hbeef, 8'h3c, 2, 1023, 4'h0, 8'h00, -1);
      chk("long_ok_len", mon_busy, 13 + 1023);
      chk("long_ok_status", mon_st, 2'b00);
      run_txn(4'h0, 16'hbeef, 8'h00, 2, 1024, 4'h0, 8'h00, -1);
      chk("long_abort_status", mon_st, 2'b10);
      run_txn(4'h0, 16'h0101, 8'h00, 3, 3, 4'h0, 8'h5a, -1);
      chk("nosync_ok_status", mon_st, 2'b00);
      chk("nosync_ok_rdata", mon_rd, 8'h5a);
      run_txn(4'h0, 16'h0101, 8'h00, 3, 4, 4'h0, 8'h00, -1);
      chk("nosync_abort_status", mon_st, 2'b10);
      run_txn(4'h0, 16'hc0de, 8'h00, 0, 0, 4'h0, 8'h11, 3);
      chk("rst_frame", lpc_frame, 1'b1);
      chk("rst_oe", lpc_ad_oe, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      run_txn(4'h0, 16'hc0de, 8'h00, 1, 2, 4'h0, 8'h93, -1);
      chk("post_rst_rdata", mon_rd, 8'h93);
      chk("post_rst_len", mon_busy, 15);
      for (int n = 0; n < 150; n++) begin
         logic [3:0] ct;
         ct = ($urandom % 10 < 7) ? (($urandom % 2 != 0) ? 4'h2 : 4'h0) : rn();
         run_txn(ct, 16'($urandom), 8'($urandom), int'($urandom % 4), int'($urandom_range(0, 5)),
                 ($urandom % 4 == 0) ? 4'ha : 4'h0, 8'($urandom),
                 ($urandom % 25 == 0) ? int'($urandom_range(0, 12)) : -1);
         idle(int'($urandom % 3));
      end
      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
